lsu_data_port: RTL

Load/store unit that sits directly upstream of the data port of the dual-port simulation memory. It accepts one load/store request at a time from the execute stage and drives the memory read/write strobes, byte-size mask and address for exactly one cycle. It returns sign- or zero-extended load data, or store completion, through a valid/ready response. Misaligned accesses are trapped locally and never reach memory.

---
 rtl/lsu_pkg.sv | 28 ++
 rtl/lsu_data_port_if.sv | 54 +++++
 rtl/lsu_load_ext.sv | 24 ++
 rtl/lsu_data_port.sv | 106 ++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit data port.
//   - RV32 funct3 size/sign codes
//   - FSM state encoding
//   - size_to_mask: converts an access size to the byte-lane mask, ordered {m0,m1,m2,m3}
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_e;

    // funct3[1:0] carries the size. Bit 0 of the result is m3, which is byte lane 0.
    function automatic logic [3:0] size_to_mask(input logic [1:0] size);
        case (size)
            2'b00:   size_to_mask = 4'b0001;
            2'b01:   size_to_mask = 4'b0011;
            default: size_to_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_data_port_if.sv
// lsu_data_port_if: request/response handshake plus the data-side memory port.
//   modport slave  : the LSU view (accepts requests, drives memory strobes)
//   modport master : execute stage + memory view (issues requests, returns read data)
interface lsu_data_port_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  iReq_bValid;
    logic                  iReq_bReady;
    logic                  iReq_bWr;
    logic [2:0]            iReq_bFunct3;
    logic [ADDR_WIDTH-1:0] iReq_bAddr;
    logic [DATA_WIDTH-1:0] iReq_bData;

    logic                  oResp_bValid;
    logic                  oResp_bReady;
    logic [DATA_WIDTH-1:0] oResp_bData;
    logic                  oResp_bErr;

    logic                  pMemData_pRd_bEn;
    logic [ADDR_WIDTH-1:0] pMemData_pRd_bAddr;
    logic [DATA_WIDTH-1:0] pMemData_pRd_bData;
    logic                  pMemData_pWr_bEn;
    logic [ADDR_WIDTH-1:0] pMemData_pWr_bAddr;
    logic [DATA_WIDTH-1:0] pMemData_pWr_bData;
    logic                  pMemData_pWr_bMask_0;
    logic                  pMemData_pWr_bMask_1;
    logic                  pMemData_pWr_bMask_2;
    logic                  pMemData_pWr_bMask_3;

    modport slave (
        input  iReq_bValid, iReq_bWr, iReq_bFunct3, iReq_bAddr, iReq_bData,
        output iReq_bReady,
        output oResp_bValid, oResp_bData, oResp_bErr,
        input  oResp_bReady,
        output pMemData_pRd_bEn, pMemData_pRd_bAddr,
        input  pMemData_pRd_bData,
        output pMemData_pWr_bEn, pMemData_pWr_bAddr, pMemData_pWr_bData,
        output pMemData_pWr_bMask_0, pMemData_pWr_bMask_1,
        output pMemData_pWr_bMask_2, pMemData_pWr_bMask_3
    );

    modport master (
        output iReq_bValid, iReq_bWr, iReq_bFunct3, iReq_bAddr, iReq_bData,
        input  iReq_bReady,
        input  oResp_bValid, oResp_bData, oResp_bErr,
        output oResp_bReady,
        input  pMemData_pRd_bEn, pMemData_pRd_bAddr,
        output pMemData_pRd_bData,
        input  pMemData_pWr_bEn, pMemData_pWr_bAddr, pMemData_pWr_bData,
        input  pMemData_pWr_bMask_0, pMemData_pWr_bMask_1,
        input  pMemData_pWr_bMask_2, pMemData_pWr_bMask_3
    );
endinterface

// File: rtl/lsu_load_ext.sv
// lsu_load_ext: combinational load-data extension.
//   funct3 : RV32 load size/sign code
//   raw    : right-justified word read from memory
//   ext    : sign/zero-extended result (raw passes through for LW and unknown codes)
module lsu_load_ext
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] raw,
    output logic [DATA_WIDTH-1:0] ext
);
    always_comb begin
        ext = raw;
        case (funct3)
            F3_B:    ext = {{(DATA_WIDTH-8){raw[7]}}, raw[7:0]};
            F3_BU:   ext = {{(DATA_WIDTH-8){1'b0}}, raw[7:0]};
            F3_H:    ext = {{(DATA_WIDTH-16){raw[15]}}, raw[15:0]};
            F3_HU:   ext = {{(DATA_WIDTH-16){1'b0}}, raw[15:0]};
            default: ext = raw;
        endcase
    end
endmodule

// File: rtl/lsu_data_port.sv
// lsu_data_port: single-outstanding load/store unit in front of the data memory port.
//   clock, reset (async, active-low)
//   bus (lsu_data_port_if.slave): request in, response out, one-cycle memory strobes out.
// Flow: IDLE accepts a request -> ACCESS (one memory cycle) -> RESP (held until taken).
// Misaligned or illegal requests go straight from IDLE to RESP with err set.
module lsu_data_port
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    lsu_data_port_if.slave   bus
);
    lsu_state_e            state_q, state_d;
    logic                  wr_p0;
    logic [2:0]            f3_p0;
    logic [ADDR_WIDTH-1:0] addr_p0;
    logic [DATA_WIDTH-1:0] data_p0;
    logic [DATA_WIDTH-1:0] resp_data_p1;
    logic                  resp_err_p1;
    logic                  req_fire;
    logic                  req_bad;
    logic                  rd_en, wr_en;
    logic [3:0]            wr_mask;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] ld_ext;

    // Ready is held low while reset is asserted even though the state already reads IDLE.
    assign bus.iReq_bReady = (state_q == IDLE) && reset;
    assign req_fire        = bus.iReq_bValid && bus.iReq_bReady;

    always_comb begin
        req_bad = 1'b0;
        case (bus.iReq_bFunct3)
            F3_B:    req_bad = 1'b0;
            F3_H:    req_bad = bus.iReq_bAddr[0];
            F3_W:    req_bad = |bus.iReq_bAddr[1:0];
            F3_BU:   req_bad = bus.iReq_bWr;
            F3_HU:   req_bad = bus.iReq_bWr | bus.iReq_bAddr[0];
            default: req_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_fire) state_d = req_bad ? RESP : ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    if (bus.oResp_bReady) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---- stage p0: request capture / stage p1: response formation ----
    // Datapath registers carry no reset; every output they feed is gated by state.
    always_ff @(posedge clock) begin
        if (req_fire) begin
            wr_p0        <= bus.iReq_bWr;
            f3_p0        <= bus.iReq_bFunct3;
            addr_p0      <= bus.iReq_bAddr;
            data_p0      <= bus.iReq_bData;
            resp_data_p1 <= '0;
            resp_err_p1  <= req_bad;
        end else if (state_q == ACCESS) begin
            resp_data_p1 <= wr_p0 ? '0 : ld_ext;
        end
    end

    lsu_load_ext #(.DATA_WIDTH(DATA_WIDTH)) u_load_ext (
        .funct3 (f3_p0),
        .raw    (bus.pMemData_pRd_bData),
        .ext    (ld_ext)
    );

    // Memory outputs decode directly from state so an asynchronous reset drops them at once.
    assign rd_en   = (state_q == ACCESS) && !wr_p0;
    assign wr_en   = (state_q == ACCESS) &&  wr_p0;
    assign wr_mask = wr_en ? size_to_mask(f3_p0[1:0]) : 4'b0000;

    always_comb begin
        wr_data = '0;
        for (int i = 0; i < 4; i++)
            wr_data[i*8 +: 8] = wr_mask[i] ? data_p0[i*8 +: 8] : 8'h00;
    end

    assign bus.pMemData_pRd_bEn     = rd_en;
    assign bus.pMemData_pRd_bAddr   = rd_en ? addr_p0 : '0;
    assign bus.pMemData_pWr_bEn     = wr_en;
    assign bus.pMemData_pWr_bAddr   = wr_en ? addr_p0 : '0;
    assign bus.pMemData_pWr_bData   = wr_data;
    assign bus.pMemData_pWr_bMask_0 = wr_mask[3];
    assign bus.pMemData_pWr_bMask_1 = wr_mask[2];
    assign bus.pMemData_pWr_bMask_2 = wr_mask[1];
    assign bus.pMemData_pWr_bMask_3 = wr_mask[0];

    assign bus.oResp_bValid = (state_q == RESP);
    assign bus.oResp_bData  = (state_q == RESP) ? resp_data_p1 : '0;
    assign bus.oResp_bErr   = (state_q == RESP) ? resp_err_p1  : 1'b0;
endmodule
